// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch handshake with
// variable-latency memory, and feeds inst/pc4/ifid_nop to the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'hff000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        ifid_nop
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    VALID
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        kill_q, kill_d;
  logic        req_d;
  logic [31:0] addr_d;
  logic [31:0] inst_d;
  logic [31:0] pc4_d;
  logic        nop_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      target_q  <= RESET_PC;
      kill_q    <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      inst      <= NOP_INST;
      pc4       <= RESET_PC + 32'd4;
      ifid_nop  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      kill_q    <= kill_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      inst      <= inst_d;
      pc4       <= pc4_d;
      ifid_nop  <= nop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    kill_d   = kill_q;
    req_d    = imem_req;
    addr_d   = imem_addr;
    inst_d   = inst;
    pc4_d    = pc4;
    nop_d    = ifid_nop;

    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        req_d   = 1'b1;
        pc_d    = redirect ? redirect_pc : pc_q;
        addr_d  = redirect ? redirect_pc : pc_q;
      end

      REQ: begin
        if (imem_ack) begin
          if (kill_q || redirect) begin
            // Stale data: reissue at once to the newest target, req stays high.
            pc_d   = redirect ? redirect_pc : target_q;
            addr_d = redirect ? redirect_pc : target_q;
            kill_d = 1'b0;
          end else begin
            inst_d  = imem_rdata;
            nop_d   = 1'b0;
            pc4_d   = pc_plus4;
            req_d   = 1'b0;
            state_d = VALID;
          end
        end else if (redirect) begin
          // Cannot abort the outstanding request; remember to drop its data.
          kill_d   = 1'b1;
          target_d = redirect_pc;
        end
      end

      VALID: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          inst_d  = NOP_INST;
          nop_d   = 1'b1;
          state_d = REQ;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          addr_d  = pc_plus4;
          req_d   = 1'b1;
          inst_d  = NOP_INST;
          nop_d   = 1'b1;
          state_d = REQ;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/latency,
// delivered instructions checked against an expected program-order queue.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hff000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        ifid_nop;

  int checks = 0;
  int errors = 0;
  int lat_force = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] gen_pc;

  fetch_stage #(.RESET_PC(32'h00000000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .pc4(pc4),
    .ifid_nop(ifid_nop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program order: after a redirect the next delivered instruction is the
  // target, then sequential words (32-bit wrap).
  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back({mem(gen_pc), gen_pc + 32'd4});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic model_redirect(input logic [31:0] t);
    exp_q.delete();
    gen_pc = t;
    topup();
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    if (r) model_redirect(rp);
    topup();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},  32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_pc4"},  pc4, 32'h4);
    chk({tag, "_nop"},  32'(ifid_nop), 32'd1);
  endtask

  // Memory responder: ack after lat_force (or random 0..3) wait cycles;
  // junk acks are thrown in while no request is pending.
  initial begin
    int cnt;
    cnt        = -1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_ack = 1'b0;
        cnt      = -1;
      end else if (!imem_req) begin
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        cnt        = -1;
      end else begin
        if (cnt < 0) cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        if (cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem(imem_addr);
          cnt        = -1;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          cnt--;
        end
      end
    end
  end

  // Monitor: just before each rising edge, pop and compare every instruction
  // the IF/ID register would capture.
  initial begin
    int   idle;
    exp_t e;
    idle = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1) begin
        if (ifid_nop) chk("bubble_inst", inst, NOP);
        else          chk("valid_req_low", 32'(imem_req), 32'd0);
        if (!ifid_nop && !stall && !redirect) begin
          idle = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_underflow: got inst %h with empty expected queue", inst);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_inst", inst, e.inst);
            chk("deliver_pc4", pc4, e.pc4);
          end
        end else begin
          idle++;
          if (idle > 100) begin
            checks++;
            errors++;
            $display("FAIL deliver_timeout: got %0d idle cycles expected at most 100", idle);
            idle = 0;
          end
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    lat_force   = 0;
    model_redirect(32'h0);

    @(negedge clk);
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // BOOT lasted one cycle; first request at RESET_PC, zero-wait ack
    step(1'b0, 1'b0, 32'h0);
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_nop", 32'(ifid_nop), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("first_inst", inst, mem(32'h0));
    chk("first_pc4", pc4, 32'h4);
    chk("first_nop", 32'(ifid_nop), 32'd0);
    #1 lat_force = 3;

    // three wait cycles at addr 4
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'h4);
      chk("wait_inst", inst, NOP);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("lat_inst", inst, mem(32'h4));
    chk("lat_pc4", pc4, 32'h8);

    // two stall cycles in VALID
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 1'b0, 32'h0);
      chk("stall_inst", inst, mem(32'h4));
      chk("stall_pc4", pc4, 32'h8);
      chk("stall_nop", 32'(ifid_nop), 32'd0);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    #1 lat_force = 0;
    step(1'b0, 1'b0, 32'h0);
    chk("post_stall_addr", imem_addr, 32'h8);

    // redirect beats stall in VALID
    step(1'b1, 1'b1, 32'h40);
    chk("pre_redir_inst", inst, mem(32'h8));
    #1 lat_force = 2;
    step(1'b0, 1'b1, 32'h80);
    chk("redir_nop", 32'(ifid_nop), 32'd1);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h40);
    #1 lat_force = 0;

    // redirect while waiting: old request completes, data dropped
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("kill_addr", imem_addr, 32'h40);
      chk("kill_inst", inst, NOP);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h80);
    step(1'b0, 1'b0, 32'h0);
    chk("target_inst", inst, mem(32'h80));
    chk("target_pc4", pc4, 32'h84);
    #1 lat_force = 3;

    // asynchronous reset in the middle of a wait
    step(1'b0, 1'b0, 32'h0);
    chk("mid_wait_addr", imem_addr, 32'h84);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_redirect(32'h0);
    #1 lat_force = 0;
    step(1'b0, 1'b0, 32'h0);
    chk("reboot_req", 32'(imem_req), 32'd1);
    chk("reboot_addr", imem_addr, 32'h0);
    #1 lat_force = -1;

    // random phase, starting with a wrap-around target
    step(1'b0, 1'b1, 32'hfffffffc);
    for (int i = 0; i < 3000; i++) begin
      logic        s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | 32'($urandom_range(0, 15))) : $urandom;
      step(s, r, t);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
